mem_bus_responder: RTL
======================

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameter ADDR_W, default 8, the internal memory holds 2^ADDR_W words of 16 bits.
REQ-002 Parameter WAIT_CYC, default 2, range 0..15, the number of wait cycles inserted before acknowledge.
REQ-003 Parameter IRQ_VEC, default 16'h0040, the word returned on an interrupt-acknowledge cycle.
REQ-004 The block SHALL use one clock, and reset SHALL be asynchronous and active-high.
REQ-005 CLK  in  1  system clock; all state updates on rising edge.
REQ-006 CLR  in  1  asynchronous active-high reset.
REQ-007 MREQ_N  in  1  memory request, active-low.
REQ-008 MIRQ_N  in  1  interrupt-acknowledge qualifier, active-low, valid with MREQ_N.
REQ-009 R_W_N  in  1  1 = read, 0 = write.
REQ-010 M_ADDR  in  16  word address.
REQ-011 M_WDATA  in  16  write data.
REQ-012 m_bus  out  16  read data / vector returned to the instruction and data path.
REQ-013 M_RDY  out  1  transfer-complete strobe, one cycle.
REQ-014 M_ERR  out  1  address-out-of-range flag, asserted with M_RDY.
REQ-015 BUSY  out  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, WAIT, ACK and HOLD.
REQ-017 In IDLE, MREQ_N=0 sampled at a rising edge SHALL latch M_ADDR, M_WDATA, R_W_N and MIRQ_N.
REQ-018 On that latching edge, the FSM SHALL go to WAIT with the counter loaded to WAIT_CYC, or go directly to ACK if WAIT_CYC=0.
REQ-019 WAIT SHALL decrement the counter each cycle and go to ACK on the edge where the counter equals 1.
REQ-020 Input changes after the latching edge SHALL be ignored until the block returns to IDLE.
REQ-021 Latency: a request sampled at edge k SHALL produce M_RDY=1 during the cycle after edge k+WAIT_CYC.
REQ-022 ACK SHALL last exactly one cycle with M_RDY=1.
REQ-023 On leaving ACK, the FSM SHALL go to IDLE if MREQ_N=1, else to HOLD.
REQ-024 HOLD SHALL go to IDLE on the first edge with MREQ_N=1, so no new request is accepted until MREQ_N has been deasserted.
REQ-025 Out of range SHALL mean latched address >= 2^ADDR_W (upper address bits nonzero).
REQ-026 A write that is in range SHALL commit to memory on the edge that enters ACK.
REQ-027 A write that is out of range, or that has MIRQ_N=0, SHALL be discarded.
REQ-028 A read that is in range SHALL drive mem[addr] on m_bus from ACK through HOLD.
REQ-029 A read that is out of range SHALL drive 16'h0000 on m_bus.
REQ-030 An interrupt-acknowledge cycle (MIRQ_N=0) SHALL drive IRQ_VEC regardless of address, with M_ERR=0.
REQ-031 m_bus SHALL be 16'h0000 in IDLE and WAIT.
REQ-032 M_ERR SHALL be 1 only in ACK for an out-of-range, non-interrupt-acknowledge access.
REQ-033 A read issued after a write to the same address SHALL return the new data.
REQ-034 MIRQ_N=0 with MREQ_N=1 SHALL be ignored.

Reset
REQ-035 While CLR=1, the state SHALL be IDLE, the counter 0, all latches 0, m_bus=16'h0000, and M_RDY=M_ERR=BUSY=0.
REQ-036 CLR asserted mid-transaction SHALL abort it, and no write SHALL commit unless it committed before CLR rose.
REQ-037 Memory contents SHALL NOT be cleared by CLR.
REQ-038 After CLR falls, the first edge with MREQ_N=0 SHALL start a new transaction.

Verification (WAIT_CYC=2, ADDR_W=8)
REQ-039 Write 16'hBEEF to address 0x0012, then read 0x0012 -> M_RDY goes high 3 cycles after each request edge and m_bus=16'hBEEF on the read.
REQ-040 Read address 0x0100 -> M_ERR=1 and M_RDY=1 together, m_bus=16'h0000; a write to 0x0100 leaves mem[0x00] unchanged.
REQ-041 MREQ_N=0 with MIRQ_N=0 and M_ADDR=0x0005 -> m_bus=16'h0040, M_ERR=0, memory unchanged.
REQ-042 MREQ_N held low for 6 cycles -> exactly one M_RDY pulse, the block stays in HOLD, and a new transaction starts only after MREQ_N goes high then low.
REQ-043 CLR pulsed during WAIT of a write of 16'h1234 to 0x0003 -> all outputs 0 and mem[0x03] keeps its prior value.
REQ-044 With WAIT_CYC=0, a read request -> M_RDY high in the cycle immediately after the request edge, and back-to-back requests spaced by MREQ_N=1 for one cycle are all served.

Source files
------------

// File: rtl/mem_bus_responder.sv
// Wait-state memory responder: latches a bus request, inserts WAIT_CYC wait
// cycles, then acknowledges with read data, an interrupt vector or an error.
module mem_bus_responder #(
    parameter int          ADDR_W   = 8,
    parameter int          WAIT_CYC = 2,
    parameter logic [15:0] IRQ_VEC  = 16'h0040
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        MREQ_N,
    input  logic        MIRQ_N,
    input  logic        R_W_N,
    input  logic [15:0] M_ADDR,
    input  logic [15:0] M_WDATA,
    output logic [15:0] m_bus,
    output logic        M_RDY,
    output logic        M_ERR,
    output logic        BUSY
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [15:0]       lat_addr;
    logic [15:0]       lat_wdata;
    logic              lat_rw;
    logic              lat_irq_n;
    logic [15:0]       mem [DEPTH];

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    function automatic logic in_range(input logic [15:0] a);
        return (a >> ADDR_W) == 16'h0000;
    endfunction

    // Commit happens on the edge entering ACK; with no wait cycles that is
    // the latching edge itself, so the live inputs are used instead.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = lat_addr[ADDR_W-1:0];
        wr_data = lat_wdata;
        if (state == S_IDLE && !MREQ_N && WAIT_CYC == 0) begin
            wr_en   = !R_W_N && MIRQ_N && in_range(M_ADDR);
            wr_addr = M_ADDR[ADDR_W-1:0];
            wr_data = M_WDATA;
        end else if (state == S_WAIT && cnt == 4'd1) begin
            wr_en = !lat_rw && lat_irq_n && in_range(lat_addr);
        end
    end

    // Memory has no reset so its contents survive CLR.
    always_ff @(posedge CLK) begin
        if (wr_en && !CLR)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            lat_addr  <= 16'h0000;
            lat_wdata <= 16'h0000;
            lat_rw    <= 1'b0;
            lat_irq_n <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!MREQ_N) begin
                        lat_addr  <= M_ADDR;
                        lat_wdata <= M_WDATA;
                        lat_rw    <= R_W_N;
                        lat_irq_n <= MIRQ_N;
                        if (WAIT_CYC == 0) begin
                            state <= S_ACK;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'(WAIT_CYC);
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= S_ACK;
                end
                S_ACK: begin
                    state <= MREQ_N ? S_IDLE : S_HOLD;
                end
                S_HOLD: begin
                    if (MREQ_N)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        m_bus = 16'h0000;
        if (state == S_ACK || state == S_HOLD) begin
            if (!lat_irq_n)
                m_bus = IRQ_VEC;
            else if (lat_rw && in_range(lat_addr))
                m_bus = mem[lat_addr[ADDR_W-1:0]];
        end
    end

    assign M_RDY = (state == S_ACK);
    assign M_ERR = (state == S_ACK) && lat_irq_n && !in_range(lat_addr);
    assign BUSY  = (state != S_IDLE);

endmodule
